// File: rtl/conv55_pkg.sv
// Shared constants for the 5x5 window path and the flat-bus slot mapping.
// Slot (r,c) sits at bit DATA_W*(5r+c); r=0 is the oldest row and c=0 is the oldest column.
package conv55_pkg;

    localparam int DATA_W     = 6;
    localparam int KERNEL_DIM = 5;
    localparam int WIN_PIX    = KERNEL_DIM * KERNEL_DIM;

    function automatic int slot_ofs(input int r, input int c);
        return DATA_W * (KERNEL_DIM * r + c);
    endfunction

endpackage

// File: rtl/conv55_window_gen_if.sv
// Pixel-stream input and flat window output for the 5x5 window generator.
// The master drives pixels and sees windows; the slave is the generator itself.
interface conv55_window_gen_if;

    logic                                             in_valid;
    logic                                             in_sof;
    logic [conv55_pkg::DATA_W-1:0]                    in_pixel;
    logic [conv55_pkg::WIN_PIX*conv55_pkg::DATA_W-1:0] win_data;
    logic                                             win_valid;
    logic                                             frame_done;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  win_data, win_valid, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output win_data, win_valid, frame_done
    );

endinterface

// File: rtl/conv55_line_buf.sv
// One image row of delay: dout is the din accepted DEPTH enables earlier. The buffer is a circular RAM.
// Reading is combinational from the current pointer. There is no backpressure; it advances on every enable.
module conv55_line_buf #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;

    // Read-before-write at the same slot yields exactly DEPTH enables of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/conv55_window_gen.sv
// Builds 5x5 windows from a raster stream and flags only fully-populated ones; a window appears 1 cycle after acceptance.
// There is no backpressure: the downstream convolution consumes every cycle.
module conv55_window_gen
    import conv55_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic               clk,
    input  logic               rst,
    conv55_window_gen_if.slave io
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_DIM - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_DIM - 1);

    logic [CW-1:0] col_cnt, col_pos;
    logic [RW-1:0] row_cnt, row_pos;
    logic          win_valid_q, frame_done_q;

    logic [KERNEL_DIM-1:0][DATA_W-1:0]                  tap;
    logic [KERNEL_DIM-1:0][KERNEL_DIM-1:0][DATA_W-1:0]  win;
    logic [WIN_PIX*DATA_W-1:0]                          win_data;

    // tap[j] is the pixel in the same column j rows earlier.
    assign tap[0] = io.in_pixel;

    for (genvar j = 1; j < KERNEL_DIM; j++) begin : g_lb
        conv55_line_buf #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_lb (
            .clk  (clk),
            .rst  (rst),
            .en   (io.in_valid),
            .din  (tap[j-1]),
            .dout (tap[j])
        );
    end

    // A start-of-frame makes this cycle's position (0,0) whether or not a pixel arrives.
    always_comb begin
        col_pos = io.in_sof ? '0 : col_cnt;
        row_pos = io.in_sof ? '0 : row_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (io.in_valid) begin
                win_valid_q  <= (row_pos >= ROW_MIN) && (col_pos >= COL_MIN);
                frame_done_q <= (row_pos == ROW_LAST) && (col_pos == COL_LAST);
                if (col_pos == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_pos == ROW_LAST) ? '0 : row_pos + 1'b1;
                end else begin
                    col_cnt <= col_pos + 1'b1;
                    row_cnt <= row_pos;
                end
            end else if (io.in_sof) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end
        end
    end

    // Row 0 is fed from the oldest line buffer and row 4 from the live pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
        end else if (io.in_valid) begin
            for (int r = 0; r < KERNEL_DIM; r++) begin
                for (int c = 0; c < KERNEL_DIM - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][KERNEL_DIM-1] <= tap[KERNEL_DIM-1-r];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < KERNEL_DIM; r++) begin
            for (int c = 0; c < KERNEL_DIM; c++) begin
                win_data[slot_ofs(r, c) +: DATA_W] = win[r][c];
            end
        end
    end

    assign io.win_data   = win_data;
    assign io.win_valid  = win_valid_q;
    assign io.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv55_window_gen.sv
// Directed bench for conv55_window_gen on an 8x8 image with pixel(r,c) = (8r+c) mod 64.
// It checks window timing and contents, gaps, row wrap, mid-frame sof, async reset and back-to-back frames.
module tb_conv55_window_gen;
    import conv55_pkg::*;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int BUS = WIN_PIX * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv55_window_gen_if bus ();

    conv55_window_gen #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cur_r = 0, cur_c = 0, last_r = 0, last_c = 0;
    int n_win = 0, n_done = 0, acc_since_sof = 0, first_win_acc = -1;
    bit exp_vld = 1'b0, exp_done = 1'b0, last_acc = 1'b0, win_known = 1'b0;
    logic [BUS-1:0] exp_win = '0;

    task automatic check(input string tag, input logic [BUS-1:0] obs, input logic [BUS-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] pix(input int r, input int c);
        return DATA_W'((W * r + c) % 64);
    endfunction

    // Window after accepting (r,c): rows r-4..r, cols c-4..c, oldest at slot 0.
    function automatic logic [BUS-1:0] win_at(input int r, input int c);
        logic [BUS-1:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                w[DATA_W*(5*i+j) +: DATA_W] = pix(r - 4 + i, c - 4 + j);
            end
        end
        return w;
    endfunction

    task automatic sample();
        check("win_valid", BUS'(bus.win_valid), BUS'(exp_vld));
        check("frame_done", BUS'(bus.frame_done), BUS'(exp_done));
        if (exp_vld) begin
            check("win_data", bus.win_data, exp_win);
            if (last_r == 4 && last_c == 4) begin
                check("first_slot0", BUS'(bus.win_data[DATA_W*0 +: DATA_W]), BUS'(0));
                check("first_slot4", BUS'(bus.win_data[DATA_W*4 +: DATA_W]), BUS'(4));
                check("first_slot20", BUS'(bus.win_data[DATA_W*20 +: DATA_W]), BUS'(32));
                check("first_slot24", BUS'(bus.win_data[DATA_W*24 +: DATA_W]), BUS'(36));
            end
            if (last_r == 5 && last_c == 4) begin
                check("wrap_slot0", BUS'(bus.win_data[DATA_W*0 +: DATA_W]), BUS'(8));
                check("wrap_slot24", BUS'(bus.win_data[DATA_W*24 +: DATA_W]), BUS'(44));
            end
        end else if (!last_acc && win_known) begin
            check("hold", bus.win_data, exp_win);
        end
        if (bus.win_valid === 1'b1) begin
            n_win++;
            if (first_win_acc < 0) first_win_acc = acc_since_sof;
        end
        if (bus.frame_done === 1'b1) n_done++;
    endtask

    task automatic cyc(input bit v, input bit sof);
        @(negedge clk);
        sample();
        bus.in_valid = v;
        bus.in_sof   = sof;
        if (sof) begin
            cur_r = 0;
            cur_c = 0;
            acc_since_sof = 0;
            first_win_acc = -1;
        end
        exp_vld  = 1'b0;
        exp_done = 1'b0;
        last_acc = v;
        if (v) begin
            bus.in_pixel = pix(cur_r, cur_c);
            exp_vld  = (cur_r >= 4) && (cur_c >= 4);
            exp_done = (cur_r == H - 1) && (cur_c == W - 1);
            if (exp_vld) begin
                exp_win   = win_at(cur_r, cur_c);
                win_known = 1'b1;
            end else begin
                win_known = 1'b0;
            end
            last_r = cur_r;
            last_c = cur_c;
            acc_since_sof++;
            cur_c++;
            if (cur_c == W) begin
                cur_c = 0;
                cur_r = (cur_r == H - 1) ? 0 : cur_r + 1;
            end
        end
    endtask

    task automatic flush();
        repeat (3) cyc(1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        repeat (3) @(negedge clk);
        check("rst_win_valid", BUS'(bus.win_valid), BUS'(0));
        check("rst_frame_done", BUS'(bus.frame_done), BUS'(0));
        check("rst_win_data", bus.win_data, BUS'(0));
        rst = 1'b0;

        // Continuous frame
        n_win = 0; n_done = 0;
        for (int k = 0; k < W * H; k++) cyc(1'b1, k == 0);
        flush();
        check("cont_windows", BUS'(n_win), BUS'(16));
        check("cont_done", BUS'(n_done), BUS'(1));
        check("cont_first_win_acc", BUS'(first_win_acc), BUS'(37));

        // Random gaps, natural wrap into a new frame
        n_win = 0; n_done = 0;
        for (int k = 0; k < W * H; k++) begin
            while ($urandom_range(1) == 0) cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
        end
        flush();
        check("gap_windows", BUS'(n_win), BUS'(16));
        check("gap_done", BUS'(n_done), BUS'(1));

        // Mid-frame sof at (3,2) discards the partial frame
        n_win = 0; n_done = 0;
        for (int k = 0; k < 3 * W + 2; k++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        for (int k = 1; k < W * H; k++) cyc(1'b1, 1'b0);
        flush();
        check("sof_first_win_acc", BUS'(first_win_acc), BUS'(37));
        check("sof_windows", BUS'(n_win), BUS'(16));
        check("sof_done", BUS'(n_done), BUS'(1));

        // Async reset while a window is presented
        for (int k = 0; k < 5 * W + 6; k++) cyc(1'b1, 1'b0);
        @(negedge clk);
        sample();
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_win_valid", BUS'(bus.win_valid), BUS'(0));
        check("arst_win_data", bus.win_data, BUS'(0));
        check("arst_frame_done", BUS'(bus.frame_done), BUS'(0));
        @(negedge clk);
        rst = 1'b0;
        cur_r = 0; cur_c = 0; exp_vld = 1'b0; exp_done = 1'b0;
        last_acc = 1'b0; win_known = 1'b0;
        n_win = 0; n_done = 0;
        for (int k = 0; k < W * H; k++) cyc(1'b1, 1'b0);
        flush();
        check("post_rst_windows", BUS'(n_win), BUS'(16));
        check("post_rst_done", BUS'(n_done), BUS'(1));

        // Back-to-back frames without idle
        n_win = 0; n_done = 0;
        for (int k = 0; k < 2 * W * H; k++) cyc(1'b1, (k % (W * H)) == 0);
        flush();
        check("b2b_windows", BUS'(n_win), BUS'(32));
        check("b2b_done", BUS'(n_done), BUS'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv55_window_gen.md
Name: conv55_window_gen

Overview:
- Upstream neighbour of the 5x5 6-bit convolution stage.
- Accepts a raster-order pixel stream, one pixel per cycle, and buffers four full image rows in line buffers.
- Presents each complete 5x5 window as a flat 25-pixel bus that maps directly onto the convolution's in_data_0..in_data_24 inputs.
- Only fully-populated windows are emitted ("valid" convolution, no padding).

Parameters:
- DATA_W, 6, pixel width in bits.
- IMG_W, 32, pixels per row; legal range 5..1024.
- IMG_H, 32, rows per frame; legal range 5..1024.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_pixel is accepted this cycle.
- in_sof  input  1  start-of-frame; meaningful with or without in_valid.
- in_pixel  input  DATA_W  raster pixel.
- win_data  output  25*DATA_W  window; slot k=5*r+c at bits [DATA_W*k +: DATA_W]; r=0 oldest row, c=0 oldest column.
- win_valid  output  1  win_data holds a new complete window this cycle.
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: win_data=0, win_valid=0, frame_done=0, col_cnt=0, row_cnt=0. Line-buffer storage is not reset; its contents are never exposed before being rewritten.
- Counters:
  - col_cnt runs 0..IMG_W-1 and row_cnt runs 0..IMG_H-1; both advance only on accepted pixels (in_valid=1).
  - col_cnt wraps to 0 after IMG_W-1, and row_cnt then increments.
  - After pixel (IMG_H-1, IMG_W-1): both counters return to 0, and frame_done=1 in the following cycle.
- Line buffers:
  - Four cascaded IMG_W-deep delay lines, one per previous row, each shifting only on an accepted pixel.
  - Tap j outputs the pixel at the same column, j rows earlier.
- Window register:
  - 5x5 array; on an accepted pixel every row shifts one column left.
  - Column 4 loads {tap4, tap3, tap2, tap1, in_pixel} for rows r=0..4.
  - No shift when in_valid=0; win_data holds its value.
- Output timing:
  - win_valid=1 exactly one cycle after accepting a pixel with row_cnt>=4 and col_cnt>=4, evaluated at acceptance.
  - At that point win_data holds pixels rows row-4..row and cols col-4..col.
  - Latency from acceptance to window is 1 cycle. Windows per frame = (IMG_W-4)*(IMG_H-4).
- Row wrap: windows straddling a row boundary (col_cnt<4) are never flagged valid, even though the register contains stale columns.
- in_sof with in_valid: counters are forced so that this pixel is (0,0). in_sof without in_valid: counters clear to 0 and nothing shifts. A mid-frame in_sof discards the partial frame and raises no frame_done.
- Gaps: in_valid may drop for any number of cycles without corrupting state.
- Backpressure: none. The downstream stage is combinational and always consumes.
- Reset mid-frame: all outputs clear immediately (asynchronously); the first pixel after reset is treated as (0,0).

Decomposition:
- Shared package (conv55_pkg): DATA_W, KERNEL_DIM=5, WIN_PIX=25, and a function returning the flat-bus bit offset of slot (r,c).
- Sub-module conv55_line_buf: a single IMG_W-deep, DATA_W-wide shift delay line with an enable. It is instantiated four times in cascade.

Test Plan:
- Setup for all tests: IMG_W=8, IMG_H=8, pixel(r,c)=(8r+c) mod 64, continuous valid.
- Continuous frame: the first win_valid comes 1 cycle after pixel (4,4) is accepted, with slot0=0, slot4=4, slot20=32 and slot24=36. Exactly 16 win_valid pulses occur, and frame_done pulses once, 1 cycle after pixel (7,7).
- Random in_valid gaps (roughly 50% duty): the sequence of windows is identical to the continuous run; win_data stays stable while in_valid=0.
- Row boundary: no win_valid after pixels (5,0) to (5,3). The window after (5,4) has slot0=8 and slot24=44.
- in_sof asserted with in_valid at pixel (3,2) mid-frame: no frame_done. The next window appears only after 37 more accepted pixels (new-frame (4,4)).
- rst pulsed asynchronously mid-frame while win_valid=1: win_valid, win_data and frame_done go to 0 without waiting for a clock edge. A full frame then produces 16 correct windows.
- Back-to-back frames with no idle cycle: the second frame's first window has slot0=0, with no contamination from the previous frame's rows.
